dmem_arbiter: RTL and testbench

- Shares the single data_mem port between two requesters: the riscv_cpu load/store path (port C) and the external loader/debug port (port E, the Ext_* path).
- Combinational grant from a registered ownership state.
- Fairness uses a wait counter (E cannot starve) and a burst limit (C cannot starve), plus an E-side lock for bulk program load.
- Sits between the CPU's memory-region-decoded signals and data_mem; IO-region traffic never reaches it.

---
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data_mem port between the CPU load/store path (C) and
//   the external loader/debug port (E). A registered ownership state selects
//   which side has priority; grants are combinational from that state.
//   E cannot starve: after MAX_WAIT consecutive denials ownership moves to E.
//   C cannot starve: after MAX_BURST E transfers with C waiting, it moves back.
//   ext_lock pins ownership on E for bulk program load.
//
// Ports
//   clk, reset            rising-edge clock, async active-low reset
//   cpu_req/we/adr/wdata  C request
//   cpu_gnt, cpu_stall    C served this cycle / C must hold (freezes PC)
//   cpu_rdata             mem_rdata passthrough
//   ext_req/we/adr/wdata  E request, ext_lock holds ownership on E
//   ext_gnt               E served this cycle
//   ext_rvalid, ext_rdata registered E read return (one cycle after grant)
//   mem_we/adr/wdata      to data_mem, all zero when nobody is granted
//   mem_rdata             from data_mem (combinational read)
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_adr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  typedef enum logic {
    OWN_CPU,
    OWN_EXT
  } ownerT;

  ownerT              owner, ownerNext;
  logic [WAIT_W-1:0]  waitCnt, waitNext;
  logic [BURST_W-1:0] burstCnt, burstNext, burstSeen;

  // Grants; both forced low while reset is asserted so no write can commit.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (reset) begin
      if (owner == OWN_EXT) begin
        ext_gnt = ext_req;
        cpu_gnt = cpu_req & ~ext_req;
      end else begin
        cpu_gnt = cpu_req;
        ext_gnt = ext_req & ~cpu_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_adr   = cpu_adr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt) begin
      mem_we    = ext_we;
      mem_adr   = ext_adr;
      mem_wdata = ext_wdata;
    end
  end

  always_comb begin
    ownerNext = owner;
    // Burst count including this cycle's transfer, so C wins the edge right
    // after the MAX_BURST-th E transfer rather than one transfer later.
    burstSeen = (ext_gnt && burstCnt != BURST_MAX) ? burstCnt + BURST_W'(1) : burstCnt;
    case (owner)
      OWN_CPU: begin
        if (ext_req && (ext_lock || (!ext_gnt && waitCnt == WAIT_LAST)))
          ownerNext = OWN_EXT;
      end
      OWN_EXT: begin
        if (!ext_lock && (!ext_req || (cpu_req && burstSeen == BURST_MAX)))
          ownerNext = OWN_CPU;
      end
      default: ownerNext = OWN_CPU;
    endcase

    waitNext = waitCnt;
    if (ext_gnt || (owner == OWN_EXT && ownerNext == OWN_CPU))
      waitNext = '0;
    else if (ext_req && waitCnt != WAIT_MAX)
      waitNext = waitCnt + WAIT_W'(1);

    burstNext = burstSeen;
    if (owner == OWN_CPU && ownerNext == OWN_EXT)
      burstNext = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner      <= OWN_CPU;
      waitCnt    <= '0;
      burstCnt   <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      owner      <= ownerNext;
      waitCnt    <= waitNext;
      burstCnt   <= burstNext;
      ext_rvalid <= ext_gnt & ~ext_we;
      if (ext_gnt && !ext_we)
        ext_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: a word memory stands in for
//   data_mem, a behavioural ownership model predicts every output each cycle,
//   and directed sequences pin the model with literal expectations.
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [31:0] cpu_adr, cpu_wdata, ext_adr, ext_wdata;
  logic        cpu_gnt, cpu_stall, ext_gnt, ext_rvalid, mem_we;
  logic [31:0] cpu_rdata, ext_rdata, mem_adr, mem_wdata, mem_rdata;

  int nChecks = 0;
  int nFails  = 0;

  dmem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_WAIT(MAX_WAIT),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_adr(ext_adr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // data_mem stand-in: combinational read, write at the rising edge.
  logic [31:0] memArr [0:1023];
  assign mem_rdata = memArr[mem_adr[11:2]];
  always @(posedge clk) if (mem_we) memArr[mem_adr[11:2]] <= mem_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mExt;            // E currently owns priority
  int          mDenied;         // consecutive E denials (capped)
  int          mTenure;         // E transfers in the current E ownership (capped)
  bit          mRv;
  logic [31:0] mRd;
  logic [31:0] refMem [0:1023];

  bit          eCg, eEg, eWe, pExt, pRv;
  logic [31:0] eAdr, eWd, pRd;
  int          pDenied, pTenure, tenureNow;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      memArr[i] = '0;
      refMem[i] = '0;
    end
    mExt = 0; mDenied = 0; mTenure = 0; mRv = 0; mRd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mExt = 0; mDenied = 0; mTenure = 0; mRv = 0; mRd = '0;
      end
      eCg = reset && cpu_req && !(mExt && ext_req);
      eEg = reset && ext_req && !(!mExt && cpu_req);
      eWe = 0; eAdr = '0; eWd = '0;
      if (eCg) begin eWe = cpu_we; eAdr = cpu_adr; eWd = cpu_wdata; end
      else if (eEg) begin eWe = ext_we; eAdr = ext_adr; eWd = ext_wdata; end

      check("cpu_gnt", 32'(cpu_gnt), 32'(eCg));
      check("ext_gnt", 32'(ext_gnt), 32'(eEg));
      check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eCg));
      check("mem_we", 32'(mem_we), 32'(eWe));
      check("mem_adr", mem_adr, eAdr);
      check("mem_wdata", mem_wdata, eWd);
      check("cpu_rdata", cpu_rdata, refMem[eAdr[11:2]]);
      check("ext_rvalid", 32'(ext_rvalid), 32'(mRv));
      check("ext_rdata", ext_rdata, mRd);

      // Ownership rules for the coming edge.
      tenureNow = mTenure + int'(eEg);
      if (tenureNow > MAX_BURST) tenureNow = MAX_BURST;
      pExt = mExt;
      if (!mExt && ext_req && (ext_lock || (!eEg && mDenied == MAX_WAIT - 1))) pExt = 1;
      if (mExt && !ext_lock && (!ext_req || (cpu_req && tenureNow == MAX_BURST))) pExt = 0;
      if (eEg || (mExt && !pExt)) pDenied = 0;
      else if (ext_req) pDenied = (mDenied + 1 > MAX_WAIT) ? MAX_WAIT : mDenied + 1;
      else pDenied = mDenied;
      pTenure = (!mExt && pExt) ? 0 : tenureNow;
      pRv = eEg && !ext_we;
      pRd = pRv ? refMem[ext_adr[11:2]] : mRd;

      @(posedge clk or negedge reset);
      if (reset) begin
        mExt = pExt; mDenied = pDenied; mTenure = pTenure; mRv = pRv; mRd = pRd;
        if (eWe) refMem[eAdr[11:2]] = eWd;
      end else begin
        mExt = 0; mDenied = 0; mTenure = 0; mRv = 0; mRd = '0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_adr = '0; ext_wdata = '0; ext_lock = 0;
  endtask

  task automatic doReset();
    step();
    reset = 0;
    idle();
    step();
    step();
    reset = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lockRun;
    idle();
    // Reset held with both requesting and a C write pending.
    reset = 0; cpu_req = 1; ext_req = 1; cpu_we = 1; cpu_adr = 32'h40; cpu_wdata = 32'h5A5A5A5A;
    sample();
    check("rst cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst ext_gnt", 32'(ext_gnt), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst ext_rvalid", 32'(ext_rvalid), 32'd0);
    step();
    reset = 1; cpu_we = 0;
    sample();
    check("post-rst cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("post-rst ext_gnt", 32'(ext_gnt), 32'd0);
    doReset();

    // C only.
    step();
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h100; cpu_wdata = 32'hDEADBEEF;
    sample();
    check("conly wr gnt", 32'(cpu_gnt), 32'd1);
    check("conly wr stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_we = 0; cpu_wdata = '0;
    sample();
    check("conly rd gnt", 32'(cpu_gnt), 32'd1);
    check("conly rd data", cpu_rdata, 32'hDEADBEEF);

    // E only.
    step();
    idle();
    ext_req = 1; ext_we = 1; ext_adr = 32'h200; ext_wdata = 32'h12345678;
    sample();
    check("eonly wr gnt", 32'(ext_gnt), 32'd1);
    step();
    ext_we = 0; ext_wdata = '0;
    sample();
    check("eonly rd gnt", 32'(ext_gnt), 32'd1);
    step();
    idle();
    sample();
    check("eonly rvalid", 32'(ext_rvalid), 32'd1);
    check("eonly rdata", ext_rdata, 32'h12345678);

    // Continuous contention: period MAX_WAIT denials + MAX_BURST grants.
    for (int k = 0; k < 2 * (MAX_WAIT + MAX_BURST); k++) begin
      step();
      cpu_req = 1; cpu_adr = 32'h100; ext_req = 1; ext_adr = 32'h200;
      sample();
      check($sformatf("contend ext_gnt c%0d", k), 32'(ext_gnt),
            32'((k % (MAX_WAIT + MAX_BURST)) >= MAX_WAIT));
      check($sformatf("contend cpu_gnt c%0d", k), 32'(cpu_gnt),
            32'((k % (MAX_WAIT + MAX_BURST)) < MAX_WAIT));
      if (k == 0) check("contend rvalid", 32'(ext_rvalid), 32'd0);
    end

    // Lock.
    doReset();
    for (int k = 0; k <= 20; k++) begin
      step();
      cpu_req = 1; ext_req = 1; ext_lock = 1;
      sample();
      check($sformatf("lock ext_gnt c%0d", k), 32'(ext_gnt), 32'(k != 0));
      check($sformatf("lock stall c%0d", k), 32'(cpu_stall), 32'(k != 0));
    end
    step();
    ext_req = 0; ext_lock = 0;
    sample();
    check("unlock cpu_gnt", 32'(cpu_gnt), 32'd1);

    // Reset during E write burst transfer 3.
    doReset();
    step();
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h30C; cpu_wdata = 32'hAAAA5555;
    for (int t = 0; t < 4; t++) begin
      step();
      idle();
      ext_req = 1; ext_we = 1; ext_lock = 1;
      ext_adr = 32'h300 + 32'(4 * t); ext_wdata = 32'h11110000 + 32'(t);
    end
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    check("midburst mem_we", 32'(mem_we), 32'd0);
    check("midburst ext_gnt", 32'(ext_gnt), 32'd0);
    step();
    reset = 1;
    idle();
    cpu_req = 1; ext_req = 1; cpu_adr = 32'h30C;
    sample();
    check("midburst keep old", cpu_rdata, 32'hAAAA5555);
    check("midburst cpu first", 32'(cpu_gnt), 32'd1);
    step();
    ext_req = 0; cpu_adr = 32'h308;
    sample();
    check("midburst t2 committed", cpu_rdata, 32'h11110002);

    // Randomized traffic with occasional lock runs and async resets.
    doReset();
    lockRun = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = 1;
      if ($urandom_range(0, 99) < 4) lockRun = !lockRun;
      cpu_req   = ($urandom_range(0, 99) < 60);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_adr   = 32'($urandom_range(0, 15)) << 2;
      cpu_wdata = $urandom;
      ext_req   = ($urandom_range(0, 99) < (lockRun ? 85 : 55));
      ext_we    = $urandom_range(0, 1) == 1;
      ext_adr   = 32'($urandom_range(0, 15)) << 2;
      ext_wdata = $urandom;
      ext_lock  = lockRun;
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        #2;
        reset = 0;
      end
    end
    step();
    reset = 1;
    idle();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
